// File: rtl/result_monitor.sv
// -----------------------------------------------------------------------------
// result_monitor
//
// Purpose:
//   Downstream checker for the stimulus driver. It recomputes the golden result
//   from the delayed monitor operands, aligns that result with the DUT output by
//   a programmable lag, and compares the two every cycle. It keeps counts of
//   tests and errors and captures the first failing vector. The checker arms
//   only after the driver reports a measured DUT delay.
//
// Parameters:
//   WIDTH   - operand/result width
//   OP      - golden op: 0 = a+b, 1 = a-b, 2 = a*b (low WIDTH bits)
//   MAX_LAG - deepest supported alignment lag, in cycles
//   CNT_W   - width of the test/error counters
//   LAG_W   - width of i_lag
//
// Ports:
//   clk_dut      in   DUT-domain clock
//   reset_n      in   asynchronous active-low reset
//   i_mon_a      in   delayed operand A from the driver
//   i_mon_b      in   delayed operand B from the driver
//   i_dut_out    in   DUT result
//   i_dut_delay  in   driver-measured DUT delay, all-ones = not yet measured
//   i_lag        in   cycles by which i_dut_out lags the matching operands
//   i_clear      in   synchronous restart, active high
//   o_state      out  one-hot FSM state (IDLE/FILL/RUN/HALT)
//   o_test_count out  number of comparisons performed
//   o_err_count  out  number of mismatches (saturating)
//   o_err_flag   out  sticky mismatch flag
//   o_fail_a     out  operand A of the first mismatch
//   o_fail_b     out  operand B of the first mismatch
//   o_fail_exp   out  golden result of the first mismatch
//   o_fail_got   out  DUT result of the first mismatch
// -----------------------------------------------------------------------------
module result_monitor #(
    parameter int WIDTH   = 32,
    parameter int OP      = 0,
    parameter int MAX_LAG = 16,
    parameter int CNT_W   = 32,
    parameter int LAG_W   = 5
) (
    input  logic             clk_dut,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_mon_a,
    input  logic [WIDTH-1:0] i_mon_b,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic [31:0]      i_dut_delay,
    input  logic [LAG_W-1:0] i_lag,
    input  logic             i_clear,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_test_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_err_flag,
    output logic [WIDTH-1:0] o_fail_a,
    output logic [WIDTH-1:0] o_fail_b,
    output logic [WIDTH-1:0] o_fail_exp,
    output logic [WIDTH-1:0] o_fail_got
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        FILL = 4'b0010,
        RUN  = 4'b0100,
        HALT = 4'b1000
    } state_t;

    localparam logic [31:0]      DELAY_UNKNOWN = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [LAG_W-1:0] LAG_LIMIT     = LAG_W'(MAX_LAG);

    state_t           state;
    state_t           state_nxt;
    logic [LAG_W-1:0] lag_q;
    logic [LAG_W-1:0] lag_nxt;
    logic [LAG_W-1:0] fill_cnt;
    logic [LAG_W-1:0] fill_nxt;

    logic [WIDTH-1:0] pipe_a   [MAX_LAG];
    logic [WIDTH-1:0] pipe_b   [MAX_LAG];
    logic [WIDTH-1:0] pipe_exp [MAX_LAG];

    logic [WIDTH-1:0] gold_now;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_exp;

    logic             cmp_valid_q;
    logic             cmp_miss_q;
    logic [WIDTH-1:0] cmp_a_q;
    logic [WIDTH-1:0] cmp_b_q;
    logic [WIDTH-1:0] cmp_exp_q;
    logic [WIDTH-1:0] cmp_got_q;

    logic [CNT_W-1:0] test_count;
    logic [CNT_W-1:0] err_count;
    logic             err_flag;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic [WIDTH-1:0] fail_exp;
    logic [WIDTH-1:0] fail_got;

    logic             delay_known;
    logic             compare_now;
    logic             commit;
    logic             test_will_sat;

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (OP)
            1:       r = a - b;
            2:       r = a * b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign delay_known = (i_dut_delay != DELAY_UNKNOWN);

    // Lag 0 compares against the live operands; any other lag picks tap lag-1
    // of the shift line, which holds the operands sampled lag cycles ago.
    always_comb begin
        gold_now = golden(i_mon_a, i_mon_b);
        sel_a    = i_mon_a;
        sel_b    = i_mon_b;
        sel_exp  = gold_now;
        for (int i = 0; i < MAX_LAG; i++) begin
            if (lag_q == LAG_W'(i + 1)) begin
                sel_a   = pipe_a[i];
                sel_b   = pipe_b[i];
                sel_exp = pipe_exp[i];
            end
        end
    end

    // A registered comparison lands one cycle after it was made. It is dropped
    // in HALT, where everything freezes, and by a clear, which zeroes the counts.
    assign commit        = cmp_valid_q && (state != HALT) && !i_clear;
    assign test_will_sat = commit && (test_count == CNT_MAX - 1'b1);

    // Next-state logic. FILL lasts lag+1 cycles so the shift line is full of
    // post-arming operands before the first comparison. Reaching the test
    // count ceiling overrides every other transition.
    always_comb begin
        state_nxt   = state;
        lag_nxt     = lag_q;
        fill_nxt    = fill_cnt;
        compare_now = 1'b0;
        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (delay_known) begin
                        state_nxt = FILL;
                        lag_nxt   = (i_lag > LAG_LIMIT) ? LAG_LIMIT : i_lag;
                        fill_nxt  = '0;
                    end
                end
                FILL: begin
                    if (!delay_known) begin
                        state_nxt = IDLE;
                    end else if (fill_cnt == lag_q) begin
                        state_nxt = RUN;
                    end else begin
                        fill_nxt = fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!delay_known) begin
                        state_nxt = IDLE;
                    end else begin
                        compare_now = 1'b1;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (test_will_sat) begin
                state_nxt = HALT;
            end
        end
    end

    // State, latched lag and fill counter.
    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lag_q    <= '0;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lag_q    <= lag_nxt;
            fill_cnt <= fill_nxt;
        end
    end

    // Operand/expected shift line. It runs in every state, so it is already
    // primed by the time FILL hands over to RUN.
    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LAG; i++) begin
                pipe_a[i]   <= '0;
                pipe_b[i]   <= '0;
                pipe_exp[i] <= '0;
            end
        end else begin
            pipe_a[0]   <= i_mon_a;
            pipe_b[0]   <= i_mon_b;
            pipe_exp[0] <= gold_now;
            for (int i = 1; i < MAX_LAG; i++) begin
                pipe_a[i]   <= pipe_a[i-1];
                pipe_b[i]   <= pipe_b[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
        end
    end

    // Comparison stage: registers the result and the vector it was made on.
    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            cmp_valid_q <= 1'b0;
            cmp_miss_q  <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_exp_q   <= '0;
            cmp_got_q   <= '0;
        end else begin
            cmp_valid_q <= compare_now;
            if (compare_now) begin
                cmp_miss_q <= (i_dut_out != sel_exp);
                cmp_a_q    <= sel_a;
                cmp_b_q    <= sel_b;
                cmp_exp_q  <= sel_exp;
                cmp_got_q  <= i_dut_out;
            end
        end
    end

    // Counters, sticky flag and first-failure capture. Only the mismatch that
    // finds the flag still clear is captured.
    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            test_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (i_clear) begin
            test_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (commit) begin
            test_count <= test_count + 1'b1;
            if (cmp_miss_q) begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                err_flag <= 1'b1;
                if (!err_flag) begin
                    fail_a   <= cmp_a_q;
                    fail_b   <= cmp_b_q;
                    fail_exp <= cmp_exp_q;
                    fail_got <= cmp_got_q;
                end
            end
        end
    end

    assign o_state      = state;
    assign o_test_count = test_count;
    assign o_err_count  = err_count;
    assign o_err_flag   = err_flag;
    assign o_fail_a     = fail_a;
    assign o_fail_b     = fail_b;
    assign o_fail_exp   = fail_exp;
    assign o_fail_got   = fail_got;

endmodule

// File: tb/tb_result_monitor.sv
// -----------------------------------------------------------------------------
// tb_result_monitor
//
// Self-checking bench for result_monitor. Random operands feed a configurable
// delay-line "DUT" (with optional bit-0 corruption of chosen results). A
// behavioural model that keeps the whole operand history in arrays predicts
// the monitor's state, counters and failure capture at every clock edge.
// A second instance with 8-bit counters and a combinational DUT exercises
// counter saturation.
// -----------------------------------------------------------------------------
module tb_result_monitor;

    localparam int HIST = 4096;

    logic        clk_dut;
    logic        reset_n;
    logic [31:0] mon_a;
    logic [31:0] mon_b;
    logic [31:0] dut_out;
    logic [31:0] dut_delay;
    logic [4:0]  lag;
    logic        clear;

    logic [3:0]  st;
    logic [31:0] test_count;
    logic [31:0] err_count;
    logic        err_flag;
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic [31:0] fail_exp;
    logic [31:0] fail_got;

    // Saturation instance: combinational adder as DUT, lag 0.
    logic [31:0] s_dut_out;
    logic [31:0] s_delay;
    logic [3:0]  s_state;
    logic [7:0]  s_test_count;
    logic [7:0]  s_err_count;
    logic        s_err_flag;
    logic [31:0] s_fail_a;
    logic [31:0] s_fail_b;
    logic [31:0] s_fail_exp;
    logic [31:0] s_fail_got;

    assign s_dut_out = mon_a + mon_b;

    result_monitor #(.WIDTH(32), .OP(0), .MAX_LAG(16), .CNT_W(32), .LAG_W(5)) dut (
        .clk_dut     (clk_dut),
        .reset_n     (reset_n),
        .i_mon_a     (mon_a),
        .i_mon_b     (mon_b),
        .i_dut_out   (dut_out),
        .i_dut_delay (dut_delay),
        .i_lag       (lag),
        .i_clear     (clear),
        .o_state     (st),
        .o_test_count(test_count),
        .o_err_count (err_count),
        .o_err_flag  (err_flag),
        .o_fail_a    (fail_a),
        .o_fail_b    (fail_b),
        .o_fail_exp  (fail_exp),
        .o_fail_got  (fail_got)
    );

    result_monitor #(.WIDTH(32), .OP(0), .MAX_LAG(16), .CNT_W(8), .LAG_W(5)) dut_sat (
        .clk_dut     (clk_dut),
        .reset_n     (reset_n),
        .i_mon_a     (mon_a),
        .i_mon_b     (mon_b),
        .i_dut_out   (s_dut_out),
        .i_dut_delay (s_delay),
        .i_lag       (5'd0),
        .i_clear     (1'b0),
        .o_state     (s_state),
        .o_test_count(s_test_count),
        .o_err_count (s_err_count),
        .o_err_flag  (s_err_flag),
        .o_fail_a    (s_fail_a),
        .o_fail_b    (s_fail_b),
        .o_fail_exp  (s_fail_exp),
        .o_fail_got  (s_fail_got)
    );

    initial clk_dut = 1'b0;
    always #5 clk_dut = ~clk_dut;

    // Stimulus history and DUT-model configuration.
    logic [31:0] hist_a [HIST];
    logic [31:0] hist_b [HIST];
    bit          hist_flip [HIST];
    int          cyc;
    int          mdelay;

    // Reference model state. Phases: 0 idle, 1 filling, 2 running, 3 halted.
    int          m_phase;
    int          m_lag;
    int          m_fill_left;
    logic [31:0] m_tc, m_ec;
    bit          m_flag;
    logic [31:0] m_fa, m_fb, m_fexp, m_fgot;
    bit          m_pend;
    bit          m_pmis;
    logic [31:0] m_pa, m_pb, m_pexp, m_pgot;

    int          tests;
    int          fails;
    logic [31:0] tc_snap;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_lag = 0; m_fill_left = 0;
        m_tc = '0; m_ec = '0; m_flag = 0;
        m_fa = '0; m_fb = '0; m_fexp = '0; m_fgot = '0;
        m_pend = 0; m_pmis = 0;
        m_pa = '0; m_pb = '0; m_pexp = '0; m_pgot = '0;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle
    // that just ended.
    task automatic modelEdge();
        bit          reach;
        bit          new_pend;
        int          src;
        logic [31:0] exp;
        reach    = 0;
        new_pend = 0;
        if (!clear && m_phase != 3 && m_pend) begin
            if (m_tc == 32'hFFFF_FFFE) reach = 1;
            m_tc = m_tc + 1;
            if (m_pmis) begin
                if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
                if (!m_flag) begin
                    m_fa = m_pa; m_fb = m_pb; m_fexp = m_pexp; m_fgot = m_pgot;
                end
                m_flag = 1;
            end
        end
        if (clear) begin
            m_phase = 0;
            m_tc = '0; m_ec = '0; m_flag = 0;
            m_fa = '0; m_fb = '0; m_fexp = '0; m_fgot = '0;
        end else begin
            case (m_phase)
                0: if (dut_delay != 32'hFFFF_FFFF) begin
                       m_phase     = 1;
                       m_lag       = (int'(lag) > 16) ? 16 : int'(lag);
                       m_fill_left = m_lag + 1;
                   end
                1: if (dut_delay == 32'hFFFF_FFFF) m_phase = 0;
                   else begin
                       m_fill_left--;
                       if (m_fill_left == 0) m_phase = 2;
                   end
                2: if (dut_delay == 32'hFFFF_FFFF) m_phase = 0;
                   else begin
                       new_pend = 1;
                       src = (cyc - m_lag < 0) ? 0 : cyc - m_lag;
                       exp = hist_a[src] + hist_b[src];
                       m_pa = hist_a[src]; m_pb = hist_b[src];
                       m_pexp = exp; m_pgot = dut_out;
                       m_pmis = (dut_out !== exp);
                   end
                default: ;
            endcase
        end
        if (reach) m_phase = 3;
        m_pend = new_pend;
    endtask

    task automatic checkOutput();
        checkEq("state", {28'd0, st}, 32'd1 << m_phase);
        checkEq("test_count", test_count, m_tc);
        checkEq("err_count", err_count, m_ec);
        checkEq("err_flag", {31'd0, err_flag}, {31'd0, m_flag});
        checkEq("fail_a", fail_a, m_fa);
        checkEq("fail_b", fail_b, m_fb);
        checkEq("fail_exp", fail_exp, m_fexp);
        checkEq("fail_got", fail_got, m_fgot);
    endtask

    // One clock cycle: present operands, derive the delayed (optionally
    // corrupted) DUT result, clock, update the model and compare.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit flip);
        int src;
        if (cyc >= HIST) begin
            $display("[TB] FAIL cycle_budget: observed %0d expected below %0d", cyc, HIST);
            $fatal(1, "[TB] history exhausted");
        end
        hist_a[cyc]    = a;
        hist_b[cyc]    = b;
        hist_flip[cyc] = flip;
        mon_a = a;
        mon_b = b;
        src = cyc - mdelay;
        if (src >= 0) dut_out = (hist_a[src] + hist_b[src]) ^ {31'd0, hist_flip[src]};
        else          dut_out = '0;
        @(posedge clk_dut);
        modelEdge();
        #1;
        checkOutput();
        cyc++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus($urandom, $urandom, 1'b0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; mdelay = 3;
        reset_n = 1'b0; clear = 1'b0; lag = 5'd3;
        dut_delay = 32'hFFFF_FFFF; s_delay = 32'hFFFF_FFFF;
        mon_a = '0; mon_b = '0; dut_out = '0;
        modelReset();
        repeat (2) @(posedge clk_dut);
        #1;
        checkEq("reset_state", {28'd0, st}, 32'h1);
        checkEq("reset_tests", test_count, 32'd0);
        checkOutput();
        reset_n = 1'b1;

        // Test 1: clean 3-stage adder, lag 3, arm after 20 cycles.
        runCycles(20);
        checkEq("t1_still_idle", {28'd0, st}, 32'h1);
        dut_delay = 32'd7;
        runCycles(1000);
        checkEq("t1_err", err_count, 32'd0);
        checkEq("t1_flag", {31'd0, err_flag}, 32'd0);
        checkEq("t1_run", {28'd0, st}, 32'h4);

        // Test 2: corrupt the result of a=5,b=7, then a second corruption.
        applyStimulus(32'd5, 32'd7, 1'b1);
        runCycles(10);
        checkEq("t2_err1", err_count, 32'd1);
        checkEq("t2_flag", {31'd0, err_flag}, 32'd1);
        checkEq("t2_fail_a", fail_a, 32'd5);
        checkEq("t2_fail_b", fail_b, 32'd7);
        checkEq("t2_fail_exp", fail_exp, 32'd12);
        checkEq("t2_fail_got", fail_got, 32'd13);
        applyStimulus(32'd9, 32'd1, 1'b1);
        runCycles(10);
        checkEq("t2_err2", err_count, 32'd2);
        checkEq("t2_keep_a", fail_a, 32'd5);
        checkEq("t2_keep_got", fail_got, 32'd13);

        // Test 3: DUT delay 4 against lag 3 mismatches from the first compare.
        clear = 1'b1;
        runCycles(1);
        clear = 1'b0;
        mdelay = 4;
        runCycles(15);
        checkEq("t3_errors_seen", {31'd0, err_count != 32'd0}, 32'd1);

        // Test 4: driver reset holds IDLE; mid-RUN loss of delay freezes counts.
        mdelay = 3;
        dut_delay = 32'hFFFF_FFFF;
        clear = 1'b1;
        runCycles(1);
        clear = 1'b0;
        runCycles(100);
        checkEq("t4_idle", {28'd0, st}, 32'h1);
        checkEq("t4_zero", test_count, 32'd0);
        dut_delay = 32'd7;
        runCycles(40);
        dut_delay = 32'hFFFF_FFFF;
        runCycles(1);
        checkEq("t4_exit_idle", {28'd0, st}, 32'h1);
        tc_snap = m_tc;
        runCycles(10);
        checkEq("t4_frozen", test_count, tc_snap);
        dut_delay = 32'd7;
        runCycles(40);
        checkEq("t4_resumed", {31'd0, test_count > tc_snap}, 32'd1);

        // Test 5: clear mid-RUN after an error, then an async reset pulse.
        applyStimulus(32'd5, 32'd7, 1'b1);
        runCycles(10);
        clear = 1'b1;
        runCycles(1);
        clear = 1'b0;
        checkEq("t5_clr_state", {28'd0, st}, 32'h1);
        checkEq("t5_clr_err", err_count, 32'd0);
        checkEq("t5_clr_flag", {31'd0, err_flag}, 32'd0);
        checkEq("t5_clr_fail", fail_got, 32'd0);
        runCycles(20);
        applyStimulus(32'd5, 32'd7, 1'b1);
        runCycles(10);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkEq("t5_rst_state", {28'd0, st}, 32'h1);
        checkEq("t5_rst_tests", test_count, 32'd0);
        checkEq("t5_rst_err", err_count, 32'd0);
        checkEq("t5_rst_flag", {31'd0, err_flag}, 32'd0);
        checkEq("t5_rst_fail", fail_exp, 32'd0);
        reset_n = 1'b1;

        // Test 6: 8-bit counter saturation, and lag 20 clamped to 16.
        lag = 5'd20;
        mdelay = 16;
        s_delay = 32'd7;
        runCycles(300);
        checkEq("t6_sat_tests", {24'd0, s_test_count}, 32'd255);
        checkEq("t6_sat_state", {28'd0, s_state}, 32'h8);
        checkEq("t6_sat_err", {24'd0, s_err_count}, 32'd0);
        checkEq("t6_sat_flag", {31'd0, s_err_flag}, 32'd0);
        checkEq("t6_lag_err", err_count, 32'd0);
        checkEq("t6_lag_run", {28'd0, st}, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
